// File: rtl/mul_final_adder.sv
// -----------------------------------------------------------------------------
// mul_final_adder
//
// Final carry-propagate stage of the 32x32 Booth/Wallace multiplier. It adds
// the redundant sum/carry vectors from the compression tree into the 64-bit
// product. It then selects the low or high word and hands the result to the
// EX pipeline over a valid/ready handshake that supports back-pressure and
// flush.
//
// Build option:
//   MUL_FINAL_ADD_TWO_STAGE_EN  defined   -> the 64-bit add is split as
//                                            32+32 over two register stages
//                                            (latency 2, capacity 2).
//                               undefined -> a single output register fed
//                                            by a full 64-bit add
//                                            (latency 1, capacity 1).
// Both builds produce identical arithmetic results.
// -----------------------------------------------------------------------------
module mul_final_adder #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      sum_i,
    input  logic [63:0]      carry_i,
    input  logic             hi_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic [TAG_W-1:0] tag_o
);

    // Output (S2) stage state, common to both builds.
    logic             out_valid_q;
    logic [31:0]      result_q;
    logic [TAG_W-1:0] tag_q;

    // What the output stage would load when it advances.
    logic             s2_valid_in;
    logic [31:0]      s2_result_d;
    logic [TAG_W-1:0] s2_tag_d;

    // Handshake terms.
    logic             s2_adv;
    logic             accept;

    // carry_i[63] has weight 2^64 and falls outside the product.
    logic             unused_carry_msb;
    assign unused_carry_msb = carry_i[63];

    // Output stage may take new data when it is empty or being drained.
    assign s2_adv = !out_valid_q | out_ready_i;

`ifdef MUL_FINAL_ADD_TWO_STAGE_EN

    // S1 pipeline register: low half already resolved, high half still
    // redundant (sum, carry, and the carry-out of the low half).
    logic             s1_valid;
    logic [32:0]      s1_lo;
    logic [31:0]      s1_sum_hi;
    logic [31:0]      s1_carry_hi;
    logic             s1_hi;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_adv;
    logic [32:0]      lo_sum;
    logic [31:0]      hi_word;

    // S1 can move when it is empty or when S2 can take its contents.
    // NOTE: every signal written in always_comb gets a value on every path
    // (here unconditionally); a missing default would infer a latch.
    always_comb begin
        s1_adv = !s1_valid | s2_adv;
        accept = in_valid_i & s1_adv & !flush_i;
    end

    // in_ready depends only on downstream state, never on in_valid_i.
    assign in_ready_o = s1_adv;

    // Low-half add: 32-bit sum plus the carry vector shifted up by one,
    // keeping the carry-out as bit 32.
    always_comb begin
        lo_sum = {1'b0, sum_i[31:0]} + {1'b0, carry_i[30:0], 1'b0};
    end

    // High-half add finishes in S2, folding in the low-half carry-out.
    always_comb begin
        hi_word = s1_sum_hi + s1_carry_hi + {31'd0, s1_lo[32]};
    end

    // Word select feeding the output register.
    always_comb begin
        s2_valid_in = s1_valid;
        s2_result_d = s1_hi ? hi_word : s1_lo[31:0];
        s2_tag_d    = s1_tag;
    end

    // S1 valid bit: cleared by flush, otherwise follows accept on advance.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= accept;
        end
    end

    // S1 data: loads only when a new operation enters the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_lo       <= '0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_hi       <= 1'b0;
            s1_tag      <= '0;
        end else if (s1_adv && accept) begin
            s1_lo       <= lo_sum;
            s1_sum_hi   <= sum_i[63:32];
            s1_carry_hi <= carry_i[62:31];
            s1_hi       <= hi_i;
            s1_tag      <= tag_i;
        end
    end

`else

    logic [63:0] product;

    // Single stage: only the output register gates acceptance.
    always_comb begin
        accept = in_valid_i & s2_adv & !flush_i;
    end

    assign in_ready_o = s2_adv;

    // Full 64-bit carry-propagate add; carry bit i has weight 2^(i+1).
    always_comb begin
        product = sum_i + {carry_i[62:0], 1'b0};
    end

    // Word select straight from the inputs into the output register.
    always_comb begin
        s2_valid_in = accept;
        s2_result_d = hi_i ? product[63:32] : product[31:0];
        s2_tag_d    = tag_i;
    end

`endif

    // Output valid: cleared by flush; a result handshaking in the flush cycle
    // has already been delivered, so dropping it here loses nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s2_valid_in;
        end
    end

    // Output data: loads only with a real result, so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            tag_q    <= '0;
        end else if (s2_adv && s2_valid_in) begin
            result_q <= s2_result_d;
            tag_q    <= s2_tag_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_mul_final_adder.sv
// -----------------------------------------------------------------------------
// tb_mul_final_adder
//
// Directed and randomised checks of mul_final_adder. Latency and capacity
// expectations follow MUL_FINAL_ADD_TWO_STAGE_EN so the same bench covers
// both builds.
// -----------------------------------------------------------------------------
module tb_mul_final_adder;

`ifdef MUL_FINAL_ADD_TWO_STAGE_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      sum;
    logic [63:0]      carry;
    logic             hi;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    mul_final_adder #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sum_i       (sum),
        .carry_i     (carry),
        .hi_i        (hi),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op with out_ready high, then measure latency and the result.
    task automatic send_and_get(input string nm, input logic [63:0] s, input logic [63:0] c,
                                input logic h, input logic [TAG_W-1:0] t, input logic [31:0] exp);
        int n;
        sum = s; carry = c; hi = h; tag = t;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({nm, "_lat"}, n, LAT);
        check({nm, "_res"}, result, exp);
        check({nm, "_tag"}, tag_out, t);
        tick();
    endtask

    logic [63:0]      bp_sum [4];
    logic [63:0]      bp_carry [4];
    logic             bp_hi [4];
    logic [31:0]      bp_exp [4];

    initial begin
        int          idx;
        int          got;
        int          cnt;
        logic        seen;
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        exp_t        e;

        // Back-pressure vectors, results worked out by hand.
        bp_sum[0] = 64'h0000_0001_0000_0002; bp_carry[0] = 64'h3;           bp_hi[0] = 1'b0; bp_exp[0] = 32'h0000_0008;
        bp_sum[1] = 64'h0000_0001_0000_0002; bp_carry[1] = 64'h3;           bp_hi[1] = 1'b1; bp_exp[1] = 32'h0000_0001;
        bp_sum[2] = 64'h0000_0000_8000_0000; bp_carry[2] = 64'h4000_0000;   bp_hi[2] = 1'b1; bp_exp[2] = 32'h0000_0001;
        bp_sum[3] = 64'h10;                  bp_carry[3] = 64'h10;          bp_hi[3] = 1'b0; bp_exp[3] = 32'h0000_0030;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sum = '0; carry = '0; hi = 1'b0; tag = '0;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_tag", tag_out, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // ---------------- directed arithmetic
        send_and_get("carry_lo", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 5'd1, 32'h0000_0001);
        send_and_get("carry_hi", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 5'd2, 32'h0000_0001);
        send_and_get("msb_drop", 64'h0, 64'h8000_0000_0000_0000, 1'b1, 5'd3, 32'h0000_0000);
        send_and_get("msb_keep", 64'h0, 64'h4000_0000_0000_0000, 1'b1, 5'd4, 32'h8000_0000);
        send_and_get("wrap_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 5'd5, 32'h0000_0000);
        send_and_get("plain_hi", 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 5'd6, 32'h1234_5678);

        // ---------------- back-pressure: stall 5 cycles with 4 ops queued
        out_ready = 1'b0; idx = 0; seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (idx < 4) begin
                sum = bp_sum[idx]; carry = bp_carry[idx]; hi = bp_hi[idx]; tag = TAG_W'(idx);
            end
            in_valid = (idx < 4);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                held = result;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", idx, CAP);
        check("bp_ready_low", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_first_res", result, bp_exp[0]);
        check("bp_hold_res", result, held);
        check("bp_hold_tag", tag_out, 0);

        out_ready = 1'b1;
        #1;
        check("bp_ready_rise", in_ready, 1);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (idx < 4) begin
                sum = bp_sum[idx]; carry = bp_carry[idx]; hi = bp_hi[idx]; tag = TAG_W'(idx);
            end
            in_valid = (idx < 4);
            #1;
            if (out_valid) begin
                check("bp_order_tag", tag_out, got);
                check("bp_order_res", result, bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_count", got, 4);
        tick();
        tick();
        check("bp_drained", out_valid, 0);

        // ---------------- flush with ops in flight and an op offered
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            sum = 64'h100 * (i + 1); carry = '0; hi = 1'b0; tag = TAG_W'(10 + i);
            in_valid = 1'b1;
            tick();
        end
        sum = 64'h77; tag = 5'd20; in_valid = 1'b1;
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("fl_deliver_valid", out_valid, 1);
        check("fl_deliver_tag", tag_out, 10);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        check("fl_quiet", cnt, 0);
        send_and_get("fl_next", 64'h5, 64'h1, 1'b0, 5'd9, 32'h0000_0007);

        // ---------------- asynchronous reset with the pipe full
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            sum = 64'hFFFF_0000_0000_0010; carry = 64'h1; hi = 1'b0; tag = TAG_W'(15 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("rm_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rm_valid", out_valid, 0);
        check("rm_result", result, 0);
        check("rm_tag", tag_out, 0);
        check("rm_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check("rm_quiet", out_valid, 0);
        send_and_get("rm_next_hi", 64'h0000_0002_0000_0003, 64'h1, 1'b1, 5'd21, 32'h0000_0002);
        send_and_get("rm_next_lo", 64'h0000_0002_0000_0003, 64'h1, 1'b0, 5'd22, 32'h0000_0005);

        // ---------------- random traffic checked against a reference multiply
        for (int cyc = 0; cyc < 6000; cyc++) begin
            a = $urandom;
            b = $urandom;
            p = {32'd0, a} * {32'd0, b};
            carry = {$urandom, $urandom};
            sum = p - {carry[62:0], 1'b0};
            hi = 1'($urandom_range(0, 1));
            tag = TAG_W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_res", result, e.res);
                    check("rnd_tag", tag_out, e.tag);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                e.res = hi ? p[63:32] : p[31:0];
                e.tag = tag;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("rnd_drain_spurious", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_drain_res", result, e.res);
                    check("rnd_drain_tag", tag_out, e.tag);
                end
            end
            @(posedge clk);
            #1;
        end
        check("rnd_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
